// File: rtl/frame_commit_ctrl.sv
// frame_commit_ctrl
//   Frame-synchronous commit controller. It collects one scene packet from the
//   UART assembler into a shadow buffer, holds it until the next vertical-blank
//   pulse, then streams it byte-by-byte into the parameter register file and
//   pulses frame_start. The register file therefore never holds a
//   half-updated triangle mid-frame.
//
//   Ports
//     clk, rst_n        clock, async active-low reset
//     rx_valid/idx/data one byte of the incoming packet (strobe)
//     rx_pkt_done       sender finished the packet (strobe)
//     vblank_start      first cycle of vertical blank (pulse)
//     wr_en/idx/data    parameter-register byte write port
//     frame_start       one-cycle pulse once the commit has completed
//     busy              packet held or being committed
//     pkt_err, err_cnt  incomplete packet dropped / saturating drop count
//     ovr               sticky: byte arrived while a packet was held
//
//   Build option: define FRAME_COMMIT_TIMEOUT_EN to add a FILL watchdog that
//   drops a stalled packet after TIMEOUT_CYC idle cycles.
module frame_commit_ctrl #(
  parameter int NUM_BYTES   = 60,
  parameter int IDX_W       = 7,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [IDX_W-1:0] rx_idx,
  input  logic [7:0]       rx_data,
  input  logic             rx_pkt_done,
  input  logic             vblank_start,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [7:0]       wr_data,
  output logic             frame_start,
  output logic             busy,
  output logic             pkt_err,
  output logic [7:0]       err_cnt,
  output logic             ovr
);
  localparam int AW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] NB = CNT_W'(NUM_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PEND, S_COPY, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [NUM_BYTES-1:0] vmask_q, vmask_d, vmask_w;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           shadow_q [NUM_BYTES];
  logic                 wr_en_q, wr_en_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 frame_start_q, frame_start_d;
  logic                 busy_q, busy_d;
  logic                 pkt_err_q, pkt_err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 in_range, byte_ok, sh_we, err_inc;
  logic [AW-1:0]        wa, ra;

`ifdef FRAME_COMMIT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  // Out-of-range indices are dropped silently everywhere (no write, no ovr).
  assign in_range = {1'b0, rx_idx} < NB;
  assign byte_ok  = rx_valid && in_range;
  assign wa       = AW'(rx_idx);
  assign ra       = AW'(cnt_q);
  assign vmask_w  = vmask_q | ({{(NUM_BYTES-1){1'b0}}, 1'b1} << wa);

  always_comb begin
    state_d       = state_q;
    vmask_d       = vmask_q;
    cnt_d         = cnt_q;
    wr_en_d       = 1'b0;
    wr_idx_d      = wr_idx_q;
    wr_data_d     = wr_data_q;
    frame_start_d = 1'b0;
    pkt_err_d     = 1'b0;
    ovr_d         = ovr_q;
    sh_we         = 1'b0;
    err_inc       = 1'b0;
`ifdef FRAME_COMMIT_TIMEOUT_EN
    wdog_d        = '0;
`endif
    case (state_q)
      S_IDLE: begin
        // A lone rx_pkt_done here belongs to nothing and is ignored.
        if (byte_ok) begin
          sh_we   = 1'b1;
          vmask_d = vmask_w;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (byte_ok) begin
          sh_we   = 1'b1;
          vmask_d = vmask_w;
        end
        // Completeness check sees a byte arriving in the same cycle.
        if (rx_pkt_done) begin
          if (&vmask_d) state_d = S_PEND;
          else begin
            err_inc = 1'b1;
            vmask_d = '0;
            state_d = S_IDLE;
          end
        end
`ifdef FRAME_COMMIT_TIMEOUT_EN
        else if (!byte_ok) begin
          if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
            err_inc = 1'b1;
            vmask_d = '0;
            state_d = S_IDLE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
`endif
      end
      S_PEND: begin
        // First write is launched from the vblank edge so wr_en rises at T+1.
        if (vblank_start) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = '0;
          wr_data_d = shadow_q[0];
          cnt_d     = CNT_W'(1);
          state_d   = S_COPY;
        end
      end
      S_COPY: begin
        if (cnt_q == NB) begin
          frame_start_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          wr_en_d   = 1'b1;
          wr_idx_d  = IDX_W'(cnt_q);
          wr_data_d = shadow_q[ra];
          cnt_d     = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        vmask_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_ok && (state_q inside {S_PEND, S_COPY, S_DONE})) ovr_d = 1'b1;
    pkt_err_d = err_inc;
    err_cnt_d = err_cnt_q + {7'd0, (err_inc && (err_cnt_q != 8'hFF))};
    busy_d    = state_d inside {S_PEND, S_COPY, S_DONE};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      vmask_q       <= '0;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_idx_q      <= '0;
      wr_data_q     <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      pkt_err_q     <= 1'b0;
      err_cnt_q     <= '0;
      ovr_q         <= 1'b0;
`ifdef FRAME_COMMIT_TIMEOUT_EN
      wdog_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      vmask_q       <= vmask_d;
      cnt_q         <= cnt_d;
      wr_en_q       <= wr_en_d;
      wr_idx_q      <= wr_idx_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      pkt_err_q     <= pkt_err_d;
      err_cnt_q     <= err_cnt_d;
      ovr_q         <= ovr_d;
`ifdef FRAME_COMMIT_TIMEOUT_EN
      wdog_q        <= wdog_d;
`endif
    end
  end

  // Shadow payload has no reset; vmask alone says what is valid.
  always_ff @(posedge clk) begin
    if (sh_we) shadow_q[wa] <= rx_data;
  end

  assign wr_en       = wr_en_q;
  assign wr_idx      = wr_idx_q;
  assign wr_data     = wr_data_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign pkt_err     = pkt_err_q;
  assign err_cnt     = err_cnt_q;
  assign ovr         = ovr_q;
endmodule

// File: tb/tb_frame_commit_ctrl.sv
`timescale 1ns/1ps
module tb_frame_commit_ctrl;
  localparam int NB = 60;
  localparam int TO = 100;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       rx_valid = 1'b0, rx_pkt_done = 1'b0, vblank_start = 1'b0;
  logic [6:0] rx_idx = '0;
  logic [7:0] rx_data = '0;
  logic       wr_en, frame_start, busy, pkt_err, ovr;
  logic [6:0] wr_idx;
  logic [7:0] wr_data, err_cnt;

  frame_commit_ctrl #(.NUM_BYTES(NB), .IDX_W(7), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_idx(rx_idx),
    .rx_data(rx_data), .rx_pkt_done(rx_pkt_done), .vblank_start(vblank_start),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .frame_start(frame_start), .busy(busy), .pkt_err(pkt_err),
    .err_cnt(err_cnt), .ovr(ovr));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  logic [47:0] wq[$];
  int          fsq[$], peq[$];
  logic        busy_h [32768];
  always @(negedge clk) begin
    if (wr_en) wq.push_back({32'(cyc), 8'(wr_idx), wr_data});
    if (frame_start) fsq.push_back(cyc);
    if (pkt_err) peq.push_back(cyc);
    if (cyc < 32768) busy_h[cyc] = busy;
  end

  // Reference model: packet contents, valid set, held/committing status.
  logic [7:0]    m_shd [NB];
  logic [7:0]    exp_c [NB];
  logic [NB-1:0] m_mask = '0;
  bit            m_pend = 0, m_ovr = 0;
  int            m_hold = 0, m_err = 0;

  task automatic model_reset();
    m_mask = '0; m_pend = 0; m_hold = 0; m_err = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit v, input int idx, input logic [7:0] d,
                            input bit done, input bit vb);
    bit was_pend, filling;
    was_pend = m_pend;
    if (m_pend || m_hold > 0) begin
      if (v && idx < NB) m_ovr = 1'b1;
    end else begin
      filling = (m_mask != '0);
      if (v && idx < NB) begin m_shd[idx] = d; m_mask[idx] = 1'b1; end
      if (done && filling) begin
        if (&m_mask) m_pend = 1'b1;
        else begin if (m_err < 255) m_err++; m_mask = '0; end
      end
    end
    if (m_hold > 0) m_hold--;
    // Held packet goes out over the next NB+1 cycles (copy plus done).
    if (vb && was_pend) begin m_pend = 0; m_hold = NB + 1; m_mask = '0; exp_c = m_shd; end
  endtask

  task automatic drive(input bit v, input int idx, input logic [7:0] d,
                       input bit done, input bit vb);
    rx_valid = v; rx_idx = 7'(idx); rx_data = d; rx_pkt_done = done; vblank_start = vb;
    model_step(v, idx, d, done, vb);
    @(posedge clk); #1;
    rx_valid = 0; rx_pkt_done = 0; vblank_start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 8'h00, 0, 0);
  endtask

  task automatic clear_logs();
    wq.delete(); fsq.delete(); peq.delete();
  endtask

  task automatic send_full_random();
    for (int k = 0; k < NB; k++) drive(1, k, 8'($urandom), 0, 0);
    drive(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({wr_en, wr_idx, wr_data, frame_start, busy, pkt_err, err_cnt, ovr} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {wr_en, wr_idx, wr_data, frame_start, busy, pkt_err, err_cnt, ovr});
    end
    rst_n = 1;
    model_reset();
    idle(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", ovr); end
  endtask

  task automatic test_commit();
    int t;
    clear_logs();
    for (int k = 0; k < NB; k++) drive(1, k, 8'(k) ^ 8'hA5, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL commit_busy_rise: got %b want 1", busy); end
    // Out-of-range bytes while held: dropped silently.
    repeat (3) drive(1, $urandom_range(127, NB), 8'($urandom), 0, 0);
    idle(100);
    n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL commit_oor_ovr: got %b want 0", ovr); end
    n_cmp++; if (wq.size() != 0) begin n_bad++; $display("FAIL commit_early_wr: got %0d want 0", wq.size()); end
    t = cyc;
    drive(0, 0, 8'h00, 0, 1);
    idle(NB + 4);
    n_cmp++; if (wq.size() != NB) begin n_bad++; $display("FAIL commit_wr_cnt: got %0d want %0d", wq.size(), NB); end
    foreach (wq[k]) begin
      n_cmp++; if (wq[k] !== {32'(t + 1 + k), 8'(k), 8'(k) ^ 8'hA5}) begin
        n_bad++; $display("FAIL commit_wr[%0d]: got %h want %h", k, wq[k], {32'(t + 1 + k), 8'(k), 8'(k) ^ 8'hA5});
      end
    end
    n_cmp++; if (fsq.size() != 1 || fsq[0] != t + NB + 1) begin
      n_bad++; $display("FAIL commit_fs: got %0d pulses first@%0d want 1@%0d", fsq.size(), (fsq.size() > 0) ? fsq[0] : -1, t + NB + 1);
    end
    n_cmp++; if (busy_h[t + NB + 1] !== 1'b1 || busy_h[t + NB + 2] !== 1'b0) begin
      n_bad++; $display("FAIL commit_busy_fall: got %b%b want 10", busy_h[t + NB + 1], busy_h[t + NB + 2]);
    end
  endtask

  task automatic test_random_order();
    int ord[NB];
    int t, j, tmp;
    clear_logs();
    for (int k = 0; k < NB; k++) ord[k] = k;
    for (int k = NB - 1; k > 0; k--) begin
      j = $urandom_range(k, 0); tmp = ord[k]; ord[k] = ord[j]; ord[j] = tmp;
    end
    repeat (8) drive(1, $urandom_range(NB - 1, 0), 8'($urandom), 0, 0);
    for (int k = 0; k < NB; k++) begin
      if ($urandom_range(3, 0) == 0) drive(1, $urandom_range(127, NB), 8'($urandom), 0, 0);
      drive(1, ord[k], 8'($urandom), 0, 0);
      if ($urandom_range(4, 0) == 0) drive(1, ord[$urandom_range(k, 0)], 8'($urandom), 0, 0);
    end
    drive(0, 0, 8'h00, 1, 0);
    idle($urandom_range(40, 1));
    t = cyc;
    drive(0, 0, 8'h00, 0, 1);
    idle(NB + 4);
    n_cmp++; if (wq.size() != NB) begin n_bad++; $display("FAIL rand_wr_cnt: got %0d want %0d", wq.size(), NB); end
    foreach (wq[k]) begin
      n_cmp++; if (wq[k] !== {32'(t + 1 + k), 8'(k), exp_c[k]}) begin
        n_bad++; $display("FAIL rand_wr[%0d]: got %h want %h", k, wq[k], {32'(t + 1 + k), 8'(k), exp_c[k]});
      end
    end
    n_cmp++; if (fsq.size() != 1 || fsq[0] != t + NB + 1) begin
      n_bad++; $display("FAIL rand_fs: got %0d pulses want 1@%0d", fsq.size(), t + NB + 1);
    end
  endtask

  task automatic test_incomplete();
    int td;
    clear_logs();
    for (int k = 0; k < NB - 1; k++) drive(1, k, 8'($urandom), 0, 0);
    td = cyc;
    drive(0, 0, 8'h00, 1, 0);
    idle(3);
    n_cmp++; if (peq.size() != 1 || peq[0] != td + 1) begin
      n_bad++; $display("FAIL incomp_pkt_err: got %0d pulses want 1@%0d", peq.size(), td + 1);
    end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL incomp_errcnt: got %0d want %0d", err_cnt, m_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL incomp_busy: got %b want 0", busy); end
    drive(0, 0, 8'h00, 0, 1);
    idle(NB + 4);
    n_cmp++; if (wq.size() != 0 || fsq.size() != 0) begin
      n_bad++; $display("FAIL incomp_no_commit: got %0d writes %0d fs want 0 0", wq.size(), fsq.size());
    end
  endtask

  task automatic test_ovr();
    int t;
    clear_logs();
    send_full_random();
    repeat (3) drive(1, $urandom_range(NB - 1, 0), 8'($urandom), 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    n_cmp++; if (ovr !== m_ovr) begin n_bad++; $display("FAIL ovr_set: got %b want %b", ovr, m_ovr); end
    t = cyc;
    drive(0, 0, 8'h00, 0, 1);
    idle(NB + 4);
    n_cmp++; if (wq.size() != NB) begin n_bad++; $display("FAIL ovr_wr_cnt: got %0d want %0d", wq.size(), NB); end
    foreach (wq[k]) begin
      n_cmp++; if (wq[k] !== {32'(t + 1 + k), 8'(k), exp_c[k]}) begin
        n_bad++; $display("FAIL ovr_wr[%0d]: got %h want %h", k, wq[k], {32'(t + 1 + k), 8'(k), exp_c[k]});
      end
    end
    n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
  endtask

  task automatic test_same_cycle();
    int t;
    clear_logs();
    for (int k = 0; k < NB - 1; k++) drive(1, k, 8'($urandom), 0, 0);
    drive(1, NB - 1, 8'($urandom), 1, 1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL same_accept: got busy %b want 1", busy); end
    idle(8);
    n_cmp++; if (wq.size() != 0 || peq.size() != 0) begin
      n_bad++; $display("FAIL same_vblank_missed: got %0d writes %0d errs want 0 0", wq.size(), peq.size());
    end
    t = cyc;
    drive(0, 0, 8'h00, 0, 1);
    idle(NB + 4);
    n_cmp++; if (wq.size() != NB) begin n_bad++; $display("FAIL same_wr_cnt: got %0d want %0d", wq.size(), NB); end
    foreach (wq[k]) begin
      n_cmp++; if (wq[k] !== {32'(t + 1 + k), 8'(k), exp_c[k]}) begin
        n_bad++; $display("FAIL same_wr[%0d]: got %h want %h", k, wq[k], {32'(t + 1 + k), 8'(k), exp_c[k]});
      end
    end
  endtask

  task automatic test_err_saturate();
    clear_logs();
    for (int i = 0; i < 260; i++) begin
      drive(1, $urandom_range(NB - 1, 0), 8'($urandom), 0, 0);
      drive(0, 0, 8'h00, 1, 0);
    end
    idle(2);
    n_cmp++; if (peq.size() != 260) begin n_bad++; $display("FAIL sat_pulses: got %0d want 260", peq.size()); end
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL sat_errcnt: got %0d want %0d", err_cnt, m_err); end
  endtask

  task automatic test_reset_midcopy();
    int t;
    clear_logs();
    send_full_random();
    t = cyc;
    drive(0, 0, 8'h00, 0, 1);
    idle(30);
    n_cmp++; if (wr_en !== 1'b1 || wr_idx !== 7'd30) begin
      n_bad++; $display("FAIL midcopy_pos: got en %b idx %0d want 1 30", wr_en, wr_idx);
    end
    #1 rst_n = 0;
    #1;
    n_cmp++; if ({wr_en, wr_idx, wr_data, frame_start, busy, pkt_err, err_cnt, ovr} !== '0) begin
      n_bad++; $display("FAIL midcopy_async_rst: got %h want 0", {wr_en, wr_idx, wr_data, frame_start, busy, pkt_err, err_cnt, ovr});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    clear_logs();
    send_full_random();
    t = cyc;
    drive(0, 0, 8'h00, 0, 1);
    idle(NB + 4);
    n_cmp++; if (wq.size() != NB) begin n_bad++; $display("FAIL recov_wr_cnt: got %0d want %0d", wq.size(), NB); end
    foreach (wq[k]) begin
      n_cmp++; if (wq[k] !== {32'(t + 1 + k), 8'(k), exp_c[k]}) begin
        n_bad++; $display("FAIL recov_wr[%0d]: got %h want %h", k, wq[k], {32'(t + 1 + k), 8'(k), exp_c[k]});
      end
    end
    n_cmp++; if (fsq.size() != 1 || fsq[0] != t + NB + 1) begin
      n_bad++; $display("FAIL recov_fs: got %0d pulses want 1@%0d", fsq.size(), t + NB + 1);
    end
  endtask

  task automatic test_timeout();
    int l;
    clear_logs();
    for (int k = 0; k < 10; k++) drive(1, k * 5, 8'($urandom), 0, 0);
    l = cyc - 1;
`ifdef FRAME_COMMIT_TIMEOUT_EN
    idle(TO + 20);
    n_cmp++; if (peq.size() != 1 || peq[0] != l + TO + 1) begin
      n_bad++; $display("FAIL timeout_pkt_err: got %0d pulses first@%0d want 1@%0d", peq.size(), (peq.size() > 0) ? peq[0] : -1, l + TO + 1);
    end
    if (m_err < 255) m_err++;
    m_mask = '0;
`else
    idle(10000);
    n_cmp++; if (peq.size() != 0) begin n_bad++; $display("FAIL no_timeout: got %0d pulses want 0 (last byte @%0d)", peq.size(), l); end
`endif
    n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL timeout_errcnt: got %0d want %0d", err_cnt, m_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_commit();
    test_random_order();
    test_incomplete();
    test_ovr();
    test_same_cycle();
    test_err_saturate();
    test_reset_midcopy();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
